// File: rtl/seg_pkg.sv
// Shared constants for the BCD/display path: FSM encodings and the
// shift-and-add-3 digit-adjust constants.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_ADJ_THRESH = 5;
    localparam int BCD_ADJ_ADD    = 3;

endpackage

// File: rtl/bcd_add3.sv
// Combinational double-dabble digit adjust: a digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3
    import seg_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);

    assign q = (d >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) ? d + BCD_DIGIT_W'(BCD_ADJ_ADD) : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock (shift-and-add-3).
// Build macro BIN2BCD_SAT_EN: saturate bcd_o to all nines on overflow.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int BIN_WIDTH = 14,
    parameter int DIG_WIDTH = 4
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [BIN_WIDTH-1:0]   bin_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [DIG_WIDTH*4-1:0] bcd_o,
    output logic                   ovf_o
);

    localparam int SCR_DIGITS = DIG_WIDTH + 1;
    localparam int SCR_W      = SCR_DIGITS * BCD_DIGIT_W;
    localparam int OUT_W      = DIG_WIDTH * BCD_DIGIT_W;
    localparam int CNT_W      = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

    state_t               state_reg, state_next;
    logic [BIN_WIDTH-1:0] bin_reg, bin_next;
    logic [SCR_W-1:0]     scr_reg, scr_next, scr_adj;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [OUT_W-1:0]     bcd_reg, bcd_next;
    logic                 ovf_reg, ovf_next;
    logic                 done_reg, done_next;
    logic                 top_nonzero;

    // The extra top scratch digit only ever holds the part that does not fit.
    assign top_nonzero = (scr_reg[SCR_W-1:OUT_W] != '0);

    generate
        for (genvar gi = 0; gi < SCR_DIGITS; gi++) begin : g_adj
            bcd_add3 u_add3 (
                .d (scr_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .q (scr_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            bin_reg   <= '0;
            scr_reg   <= '0;
            cnt_reg   <= '0;
            bcd_reg   <= '0;
            ovf_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            bin_reg   <= bin_next;
            scr_reg   <= scr_next;
            cnt_reg   <= cnt_next;
            bcd_reg   <= bcd_next;
            ovf_reg   <= ovf_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start_i) state_next = ST_SHIFT;
            ST_SHIFT: if (cnt_reg == '0) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bin_next  = bin_reg;
        scr_next  = scr_reg;
        cnt_next  = cnt_reg;
        bcd_next  = bcd_reg;
        ovf_next  = ovf_reg;
        done_next = 1'b0;
        busy_o    = (state_reg != ST_IDLE);
        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    bin_next = bin_i;
                    scr_next = '0;
                    cnt_next = CNT_W'(BIN_WIDTH - 1);
                end
            end
            ST_SHIFT: begin
                {scr_next, bin_next} = {scr_adj, bin_reg} << 1;
                if (cnt_reg != '0) cnt_next = cnt_reg - 1'b1;
            end
            ST_DONE: begin
                done_next = 1'b1;
                ovf_next  = top_nonzero;
`ifdef BIN2BCD_SAT_EN
                bcd_next  = top_nonzero ? {DIG_WIDTH{4'h9}} : scr_reg[OUT_W-1:0];
`else
                bcd_next  = scr_reg[OUT_W-1:0];
`endif
            end
            default: ;
        endcase
    end

    assign done_o = done_reg;
    assign bcd_o  = bcd_reg;
    assign ovf_o  = ovf_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed vector table, back-to-back,
// mid-conversion reset and a random sweep against an arithmetic reference.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [13:0] bin_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] bcd_o;
    logic        ovf_o;

    int n_vec = 0;
    int n_err = 0;

    bin2bcd_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .bin_i   (bin_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .bcd_o   (bcd_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Decimal digits by plain division; overflow means value >= 10^4.
    function automatic void ref_model(input int v, output logic [15:0] b, output logic o);
        int r;
        o = (v >= 10000);
        r = v % 10000;
`ifdef BIN2BCD_SAT_EN
        if (o) r = 9999;
`endif
        b = '0;
        for (int k = 0; k < 4; k++) begin
            b[4*k +: 4] = 4'((r / (10 ** k)) % 10);
        end
    endfunction

    // Called at a negedge with the DUT idle.
    task automatic run_conv(input int v, input logic [15:0] exp_bcd, input logic exp_ovf);
        logic [15:0] prev;
        int cyc, hold_bad, busy_bad;
        bit got;
        prev = bcd_o;
        start_i = 1'b1;
        bin_i = 14'(v);
        cyc = 0; got = 0; hold_bad = 0; busy_bad = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start_i = 1'b0;
                bin_i = 14'($urandom);
            end
            if (done_o) got = 1;
            else begin
                if (bcd_o !== prev) hold_bad++;
                if (busy_o !== 1'b1) busy_bad++;
            end
        end
        check("done_seen", 32'(got), 32'd1);
        check("latency", 32'(cyc), 32'd16);
        check("bcd", 32'(bcd_o), 32'(exp_bcd));
        check("ovf", 32'(ovf_o), 32'(exp_ovf));
        check("busy_at_done", 32'(busy_o), 32'd0);
        check("hold_during_conv", 32'(hold_bad), 32'd0);
        check("busy_during_conv", 32'(busy_bad), 32'd0);
        $display("conv bin=%0d bcd=%h ovf=%0d latency=%0d", v, bcd_o, ovf_o, cyc);
        @(negedge clk);
        check("done_width", 32'(done_o), 32'd0);
    endtask

    initial begin
        vec_t vecs[9];
        logic [15:0] eb;
        logic        eo;
        int cyc, hold_bad, dcnt, bcnt, v;

        vecs[0] = '{1234,  16'h1234, 1'b0};
        vecs[1] = '{0,     16'h0000, 1'b0};
        vecs[2] = '{9999,  16'h9999, 1'b0};
`ifdef BIN2BCD_SAT_EN
        vecs[3] = '{10000, 16'h9999, 1'b1};
        vecs[4] = '{16383, 16'h9999, 1'b1};
`else
        vecs[3] = '{10000, 16'h0000, 1'b1};
        vecs[4] = '{16383, 16'h6383, 1'b1};
`endif
        vecs[5] = '{5,     16'h0005, 1'b0};
        vecs[6] = '{4999,  16'h4999, 1'b0};
        vecs[7] = '{8765,  16'h8765, 1'b0};
        vecs[8] = '{1,     16'h0001, 1'b0};

        rst = 1'b1; start_i = 1'b0; bin_i = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_bcd", 32'(bcd_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf);

        // start_i held high: second conversion starts right after the done cycle.
        start_i = 1'b1; bin_i = 14'd42;
        @(negedge clk);
        bin_i = 14'd77;
        cyc = 1;
        while (!done_o && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_lat1", 32'(cyc), 32'd16);
        check("b2b_bcd1", 32'(bcd_o), 32'h0042);
        $display("conv bin=42 bcd=%h ovf=%0d latency=%0d", bcd_o, ovf_o, cyc);
        cyc = 0; hold_bad = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done_o) break;
            if (bcd_o !== 16'h0042) hold_bad++;
        end
        start_i = 1'b0;
        check("b2b_lat2", 32'(cyc), 32'd16);
        check("b2b_bcd2", 32'(bcd_o), 32'h0077);
        check("b2b_hold", 32'(hold_bad), 32'd0);
        $display("conv bin=77 bcd=%h ovf=%0d latency=%0d", bcd_o, ovf_o, cyc);
        @(negedge clk);
        check("b2b_no_third", 32'(busy_o), 32'd0);

        // Reset in the middle of a conversion.
        run_conv(5678, 16'h5678, 1'b0);
        start_i = 1'b1; bin_i = 14'd321;
        @(negedge clk);
        start_i = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_done", 32'(done_o), 32'd0);
        check("arst_bcd", 32'(bcd_o), 32'd0);
        check("arst_ovf", 32'(ovf_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0; bcnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (done_o) dcnt++;
            if (busy_o) bcnt++;
        end
        check("arst_no_done", 32'(dcnt), 32'd0);
        check("arst_no_busy", 32'(bcnt), 32'd0);
        check("arst_bcd_held", 32'(bcd_o), 32'd0);
        $display("reset abort: done pulses=%0d busy cycles=%0d", dcnt, bcnt);
        run_conv(321, 16'h0321, 1'b0);

        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(0, 16383));
            ref_model(v, eb, eo);
            run_conv(v, eb, eo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
